// File: rtl/core_scheduler_if.sv
// core_scheduler_if: fetcher handshake, pipeline strobes and
// decoder/LSU/PC-unit feedback shared by the core scheduler.
interface core_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
);
  logic                                 fetch_req;
  logic                                 fetch_done;
  logic [PC_BITS-1:0]                   current_pc;
  logic                                 decode_en;
  logic                                 request_en;
  logic                                 execute_en;
  logic                                 update_en;
  logic                                 is_ldr;
  logic                                 is_str;
  logic                                 is_halt;
  logic [THREADS_PER_BLOCK-1:0]         lsu_busy;
  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc;

  modport master (
    output fetch_req, current_pc,
    output decode_en, request_en,
    output execute_en, update_en,
    input  fetch_done,
    input  is_ldr, is_str, is_halt,
    input  lsu_busy, next_pc
  );

  modport slave (
    input  fetch_req, current_pc,
    input  decode_en, request_en,
    input  execute_en, update_en,
    output fetch_done,
    output is_ldr, is_str, is_halt,
    output lsu_busy, next_pc
  );
endinterface

// File: rtl/core_scheduler.sv
// core_scheduler: per-core SIMT sequencing FSM and shared PC.
// Optional macro DIVERGENCE_CHECK_EN: stop on lane PC mismatch.
module core_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int CNT_BITS          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [THREADS_PER_BLOCK-1:0] thread_enable,
  core_scheduler_if.master             bus,
  output logic [2:0]                   core_state,
  output logic                         done,
  output logic [CNT_BITS-1:0]          instr_count,
  output logic                         diverge_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t             state;
  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] lead_pc;
  logic               lead_found;
  logic               mismatch;
  logic               mem_op;
  logic               lanes_idle;

  assign mem_op     = bus.is_ldr | bus.is_str;
  assign lanes_idle = (bus.lsu_busy & thread_enable) == '0;

  // PC of the lowest-index enabled lane, lane 0 when none enabled
  always_comb begin
    lead_pc    = bus.next_pc[PC_BITS-1:0];
    lead_found = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_enable[i] && !lead_found) begin
        lead_pc    = bus.next_pc[i*PC_BITS +: PC_BITS];
        lead_found = 1'b1;
      end
    end
  end

`ifdef DIVERGENCE_CHECK_EN
  // any enabled lane disagreeing with the lead lane diverges
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_enable[i] &&
          bus.next_pc[i*PC_BITS +: PC_BITS] != lead_pc)
        mismatch = 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

  // sequencing FSM, PC and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      instr_count <= '0;
      diverge_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_FETCH;
            pc_q        <= '0;
            instr_count <= '0;
          end
        end
        S_FETCH: begin
          if (bus.fetch_done)
            state <= S_DECODE;
        end
        S_DECODE:  state <= S_REQUEST;
        S_REQUEST: state <= S_WAIT;
        S_WAIT: begin
          if (!mem_op || lanes_idle)
            state <= S_EXECUTE;
        end
        S_EXECUTE: state <= S_UPDATE;
        S_UPDATE: begin
          instr_count <= instr_count + 1'b1;
          if (bus.is_halt) begin
            state <= S_DONE;
          end else begin
            pc_q <= lead_pc;
            if (mismatch) begin
              diverge_err <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign core_state     = state;
  assign bus.current_pc = pc_q;
  assign bus.fetch_req  = state == S_FETCH;
  assign bus.decode_en  = state == S_DECODE;
  assign bus.request_en = state == S_REQUEST;
  assign bus.execute_en = state == S_EXECUTE;
  assign bus.update_en  = state == S_UPDATE;
  assign done           = state == S_DONE;

endmodule

// File: tb/tb_core_scheduler.sv
// tb_core_scheduler: directed instruction timelines checked
// cycle by cycle against an instruction-level model.
module tb_core_scheduler;
  localparam int T  = 4;
  localparam int PB = 8;
  localparam int CB = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1,
    S_DECODE = 3'd2, S_REQUEST = 3'd3, S_WAIT = 3'd4,
    S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [T-1:0]  thread_enable;
  logic [2:0]    core_state;
  logic          done;
  logic [CB-1:0] instr_count;
  logic          diverge_err;

  core_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) bus ();

  core_scheduler #(
    .THREADS_PER_BLOCK(T), .PC_BITS(PB), .CNT_BITS(CB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_enable (thread_enable),
    .bus           (bus.master),
    .core_state    (core_state),
    .done          (done),
    .instr_count   (instr_count),
    .diverge_err   (diverge_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic [PB-1:0] pc;
    logic [CB-1:0] cnt;
    logic          err;
  } exp_t;

  typedef struct {
    int     id;
    longint act;
    longint exp;
  } lit_t;

  exp_t q[$];
  lit_t lq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wait_cnt = 0;

  logic [PB-1:0] m_pc;
  logic [CB-1:0] m_cnt;
  logic          m_err;

  function automatic logic [PB-1:0] lead(
    logic [T-1:0] en, logic [T*PB-1:0] v);
    for (int i = 0; i < T; i++)
      if (en[i]) return v[i*PB +: PB];
    return v[PB-1:0];
  endfunction

`ifdef DIVERGENCE_CHECK_EN
  function automatic bit differ(
    logic [T-1:0] en, logic [T*PB-1:0] v);
    for (int i = 0; i < T; i++)
      if (en[i] && v[i*PB +: PB] != lead(en, v)) return 1'b1;
    return 1'b0;
  endfunction
`endif

  function automatic string lname(int id);
    case (id)
      0: return "idle_state";   1: return "idle_pc";
      2: return "idle_cnt";     3: return "idle_strobes";
      4: return "alu_pc";       5: return "alu_cnt";
      6: return "alu_state";    7: return "mem_wait5";
      8: return "mem_wait1";    9: return "lowlane_pc";
      10: return "noen_wait";   11: return "noen_pc";
      12: return "wrap_pc";     13: return "div_err";
      14: return "div_state";   15: return "div_pc";
      16: return "rst_state";   17: return "rst_pc";
      18: return "rst_strobes"; 19: return "halt_done";
      20: return "halt_cnt";    21: return "halt_pc";
      22: return "div_cnt";
      default: return "lit";
    endcase
  endfunction

  // one compare process: model timeline and literal pins
  always @(negedge clk) begin
    exp_t       e;
    lit_t       l;
    logic [5:0] sa, se;
    cyc++;
    if (core_state === S_WAIT) wait_cnt++;
    if (q.size() > 0) begin
      e  = q.pop_front();
      sa = {bus.fetch_req, bus.decode_en, bus.request_en,
            bus.execute_en, bus.update_en, done};
      se = {e.st == S_FETCH, e.st == S_DECODE,
            e.st == S_REQUEST, e.st == S_EXECUTE,
            e.st == S_UPDATE, e.st == S_DONE};
      checks++;
      if (core_state !== e.st || sa !== se ||
          bus.current_pc !== e.pc || instr_count !== e.cnt ||
          diverge_err !== e.err) begin
        errors++;
        $display("FAIL cycle %0d: state %0d want %0d, strobes %b want %b, pc %h want %h, cnt %0d want %0d, err %b want %b",
          cyc, core_state, e.st, sa, se, bus.current_pc, e.pc,
          instr_count, e.cnt, diverge_err, e.err);
      end
    end
    while (lq.size() > 0) begin
      l = lq.pop_front();
      checks++;
      if (l.act != l.exp) begin
        errors++;
        $display("FAIL %s: got %0d want %0d",
          lname(l.id), l.act, l.exp);
      end
    end
  end

  task automatic lit(int id, longint act, longint exp);
    lit_t l;
    l.id = id; l.act = act; l.exp = exp;
    lq.push_back(l);
  endtask

  task automatic step(logic [2:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    e.st = st; e.pc = m_pc; e.cnt = m_cnt; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    m_pc = '0; m_cnt = '0; m_err = 1'b0;
    repeat (n) step(S_IDLE);
    reset = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    m_pc = '0; m_cnt = '0;
    step(S_FETCH);
    start = 1'b0;
  endtask

  task automatic instr(int fd, bit mem, int busy_n,
                       logic [T-1:0] mask, bit halt,
                       logic [T-1:0] en, logic [T*PB-1:0] npc);
    bit blocked, in_wait;
    thread_enable  = en;
    bus.next_pc    = npc;
    bus.fetch_done = 1'b0;
    repeat (fd) step(S_FETCH);
    bus.fetch_done = 1'b1;
    step(S_DECODE);
    bus.fetch_done = 1'b0;
    bus.is_ldr  = mem;
    bus.is_str  = 1'b0;
    bus.is_halt = halt;
    step(S_REQUEST);
    if (busy_n > 0) bus.lsu_busy = mask;
    step(S_WAIT);
    blocked = mem && ((mask & en) != '0);
    in_wait = 1'b1;
    for (int k = 0; k < busy_n && in_wait; k++) begin
      bus.lsu_busy = mask;
      if (blocked) step(S_WAIT);
      else begin step(S_EXECUTE); in_wait = 1'b0; end
    end
    bus.lsu_busy = '0;
    if (in_wait) step(S_EXECUTE);
    step(S_UPDATE);
    m_cnt = m_cnt + 1'b1;
    if (halt) begin
      step(S_DONE);
    end else begin
      m_pc = lead(en, npc);
`ifdef DIVERGENCE_CHECK_EN
      if (differ(en, npc)) begin
        m_err = 1'b1;
        step(S_DONE);
      end else
`endif
      step(S_FETCH);
    end
    bus.is_ldr  = 1'b0;
    bus.is_halt = 1'b0;
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; thread_enable = '1;
    bus.fetch_done = 1'b0; bus.is_ldr = 1'b0;
    bus.is_str = 1'b0; bus.is_halt = 1'b0;
    bus.lsu_busy = '0; bus.next_pc = '0;

    do_reset(2);
    step(S_IDLE);
    step(S_IDLE);
    lit(0, core_state, 0);
    lit(1, bus.current_pc, 0);
    lit(2, instr_count, 0);
    lit(3, {bus.fetch_req, bus.decode_en, bus.request_en,
            bus.execute_en, bus.update_en, done}, 0);

    launch();
    instr(0, 0, 0, '0, 0, 4'hf, {4{8'h01}});
    lit(4, bus.current_pc, 1);
    lit(5, instr_count, 1);
    lit(6, core_state, 1);

    instr(2, 0, 0, '0, 0, 4'hf, {4{8'h02}});

    w0 = wait_cnt;
    instr(0, 1, 4, 4'b0100, 0, 4'hf, {4{8'h03}});
    lit(7, wait_cnt - w0, 5);

    instr(0, 0, 3, 4'hf, 0, 4'hf, {4{8'h04}});

    w0 = wait_cnt;
    instr(0, 1, 4, 4'b0100, 0, 4'b1011, {4{8'h06}});
    lit(8, wait_cnt - w0, 1);

    instr(1, 0, 0, '0, 0, 4'b1100,
          {8'd7, 8'd7, 8'd9, 8'd4});
    lit(9, bus.current_pc, 7);

    w0 = wait_cnt;
    instr(0, 1, 3, 4'hf, 0, 4'b0000,
          {8'h11, 8'h22, 8'h33, 8'hff});
    lit(10, wait_cnt - w0, 1);
    lit(11, bus.current_pc, 255);

    instr(0, 0, 0, '0, 0, 4'hf, {4{8'h00}});
    lit(12, bus.current_pc, 0);

    instr(0, 0, 0, '0, 0, 4'hf,
          {8'd5, 8'd6, 8'd5, 8'd5});
    lit(15, bus.current_pc, 5);
    lit(22, instr_count, 9);
`ifdef DIVERGENCE_CHECK_EN
    lit(13, diverge_err, 1);
    lit(14, core_state, 7);
`else
    lit(13, diverge_err, 0);
    lit(14, core_state, 1);
`endif

    do_reset(1);
    launch();
    instr(0, 0, 0, '0, 0, 4'hf, {4{8'h09}});
    thread_enable  = 4'hf;
    bus.fetch_done = 1'b1;
    step(S_DECODE);
    bus.fetch_done = 1'b0;
    bus.is_ldr = 1'b1;
    step(S_REQUEST);
    bus.lsu_busy = 4'hf;
    step(S_WAIT);
    step(S_WAIT);
    do_reset(1);
    lit(16, core_state, 0);
    lit(17, bus.current_pc, 0);
    lit(18, {bus.fetch_req, bus.decode_en, bus.request_en,
             bus.execute_en, bus.update_en, done}, 0);
    bus.lsu_busy = '0;
    bus.is_ldr = 1'b0;
    step(S_IDLE);

    launch();
    instr(0, 0, 0, '0, 0, 4'hf, {4{8'h01}});
    instr(0, 0, 0, '0, 0, 4'hf, {4{8'h02}});
    instr(0, 0, 0, '0, 1, 4'hf, {4{8'hee}});
    start = 1'b1;
    step(S_DONE);
    step(S_DONE);
    start = 1'b0;
    step(S_DONE);
    lit(19, done, 1);
    lit(20, instr_count, 3);
    lit(21, bus.current_pc, 2);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
Per-core control FSM that sequences one SIMT instruction at a time through fetch, decode, operand request, memory wait, execute and register update for all threads of a block. It drives the fetcher handshake and the decode/request/execute/update strobes consumed by the decoder, register files, ALUs and LSUs. It owns the core's shared program counter and detects kernel completion on HALT.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes in the core
PC_BITS, 8, program counter width
CNT_BITS, 16, width of the retired-instruction counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  launch the block; sampled in IDLE only
thread_enable  in  THREADS_PER_BLOCK  lanes active for this block
fetch_done  in  1  fetcher has an instruction ready; honoured in FETCH only
is_ldr  in  1  registered decoder flag
is_str  in  1  registered decoder flag
is_halt  in  1  registered decoder flag
lsu_busy  in  THREADS_PER_BLOCK  per-lane LSU request outstanding
next_pc  in  THREADS_PER_BLOCK*PC_BITS  per-lane next PC, lane i at [i*PC_BITS +: PC_BITS]
core_state  out  3  current FSM state encoding
current_pc  out  PC_BITS  PC of the instruction in flight
fetch_req  out  1  request instruction at current_pc
decode_en  out  1  decode strobe
request_en  out  1  register-read / LSU issue strobe
execute_en  out  1  ALU / PC-unit strobe
update_en  out  1  register write-back / NZP update strobe
done  out  1  block finished
instr_count  out  CNT_BITS  retired-instruction count
diverge_err  out  1  sticky divergence flag (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, and dominates every other input. On reset: core_state=IDLE, current_pc=0, instr_count=0, done=0, diverge_err=0, all strobes 0. Reset mid-instruction aborts to IDLE; there is no draining.
- States: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- Strobes are Moore outputs decoded from the registered state:
  - fetch_req=(FETCH), decode_en=(DECODE), request_en=(REQUEST), execute_en=(EXECUTE), update_en=(UPDATE), done=(DONE).
- Transitions:
  - IDLE: start=1 -> FETCH, current_pc<=0, instr_count<=0. start is ignored in every other state.
  - FETCH: hold fetch_req until fetch_done=1 -> DECODE. fetch_done may arrive in the first FETCH cycle.
  - DECODE: 1 cycle -> REQUEST. Decoder flags are valid from the REQUEST cycle onward.
  - REQUEST: 1 cycle -> WAIT.
  - WAIT:
    - Exit -> EXECUTE when (lsu_busy & thread_enable)==0, checked every cycle including the first.
    - If is_ldr=0 and is_str=0, exit -> EXECUTE unconditionally after 1 cycle.
    - thread_enable=0 means no lane can block.
  - EXECUTE: 1 cycle -> UPDATE.
  - UPDATE: instr_count<=instr_count+1, wrapping at 2^CNT_BITS.
    - is_halt=1 -> DONE; current_pc is unchanged.
    - Otherwise current_pc<=next_pc of the lowest-index enabled lane (lane 0 if none enabled) -> FETCH.
  - DONE: terminal; held until reset.
- Minimum latency for a non-memory instruction is 6 cycles (FETCH..UPDATE) with fetch_done arriving on the first FETCH cycle.
- PC wrap: next_pc is taken verbatim; a value of 2^PC_BITS-1 followed by 0 needs no special handling.

Optional Feature:
Macro DIVERGENCE_CHECK_EN.
- Defined: in UPDATE with is_halt=0, compare next_pc across all enabled lanes. On any mismatch, set diverge_err=1 (sticky until reset) and go to DONE instead of FETCH. current_pc and instr_count still update.
- Not defined: no comparison; diverge_err is tied 0.

Test Plan:
- Reset then idle: assert reset 2 cycles, start=0 -> core_state=0, all strobes 0, current_pc=0, instr_count=0.
- ALU sequence: start=1, fetch_done=1 on first FETCH cycle, is_ldr=is_str=is_halt=0, next_pc all lanes=8'h01 -> strobes pulse in order fetch/decode/request/execute/update, one cycle each (WAIT 1 cycle). After 6 cycles: current_pc=1, instr_count=1, back in FETCH.
- Memory wait: is_ldr=1, thread_enable=4'b1111, lsu_busy=4'b0100 for 5 cycles then 0 -> WAIT lasts exactly 5 cycles; execute_en asserts the cycle after lsu_busy clears. Repeat with thread_enable=4'b1011 -> WAIT exits after 1 cycle.
- Halt: program of 3 instructions, third with is_halt=1 -> done=1 after its UPDATE, instr_count=3, current_pc=2. start pulses afterwards are ignored.
- Reset mid-WAIT: reset=1 while core_state=4 and lsu_busy held -> next cycle core_state=0, current_pc=0, all strobes 0.
- DIVERGENCE_CHECK_EN: next_pc lanes {5,5,6,5}, all enabled -> diverge_err=1, core_state=7. Without the macro the same stimulus gives current_pc=5, FETCH, diverge_err=0.
